// File: rtl/mux64_scan_ctrl.sv
// mux64_scan_ctrl
// Scan sequencer for a 64:1 bit multiplexer. On an accepted start it walks
// mux_sel through every enabled channel in ascending order, holds each select
// for SETTLE cycles, samples mux_out into snapshot, and closes the scan with
// a one-cycle done pulse.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; outputs hold their last scan result
// S_WAIT | settling on the current channel, sampling on the last cycle
// S_DONE | one-cycle done pulse, then back to S_IDLE

module mux64_scan_ctrl #(
    parameter int unsigned SETTLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] mask,
    input  logic        mux_out,
    output logic [5:0]  mux_sel,
    output logic [63:0] snapshot,
    output logic [6:0]  scan_cnt,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    // The settle counter counts up from 0; the sample happens on the edge
    // where it reaches SETTLE-1, so SETTLE=1 samples on the first WAIT edge.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t      state;
    logic [63:0] mask_q;
    logic [3:0]  settle_cnt;

    logic [63:0] above_mask;
    logic        next_found;
    logic [5:0]  next_sel;
    logic [5:0]  first_sel;

    // Index of the lowest set bit; returns 0 for an all-zero vector, callers
    // qualify with a separate non-zero test.
    function automatic logic [5:0] lowest_set(input logic [63:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

    // Next-channel search: latched mask with bits 0..mux_sel cleared, then a
    // priority encode. No wrap-around, so channel 63 leaves nothing above it.
    always_comb begin
        above_mask = mask_q & (({64{1'b1}} << mux_sel) << 1);
        next_found = |above_mask;
        next_sel   = lowest_set(above_mask);
        first_sel  = lowest_set(mask);
    end

    // Scan FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mask_q     <= '0;
            settle_cnt <= '0;
            mux_sel    <= '0;
            snapshot   <= '0;
            scan_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask_q     <= mask;
                        snapshot   <= '0;
                        scan_cnt   <= '0;
                        settle_cnt <= '0;
                        if (|mask) begin
                            mux_sel <= first_sel;
                            busy    <= 1'b1;
                            state   <= S_WAIT;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        snapshot[mux_sel] <= mux_out;
                        scan_cnt          <= scan_cnt + 7'd1;
                        settle_cnt        <= '0;
                        if (next_found) begin
                            mux_sel <= next_sel;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux64_scan_ctrl.sv
// Testbench for mux64_scan_ctrl: two instances (SETTLE=2 and SETTLE=5) share
// stimulus and are checked every cycle against a timeline model that derives
// outputs from the edge count since the accepted start.

module tb_mux64_scan_ctrl;

    localparam logic [63:0] IN_FIXED = 64'h0123_4567_89ab_cdef;
    localparam logic [63:0] ALL_ONES = {64{1'b1}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] mask = '0;
    logic [63:0] in_data = IN_FIXED;

    logic [5:0]  sel2, sel5;
    logic [63:0] snap2, snap5;
    logic [6:0]  cnt2, cnt5;
    logic        busy2, busy5, done2, done5;
    logic        mo2, mo5;

    assign mo2 = in_data[sel2];
    assign mo5 = in_data[sel5];

    mux64_scan_ctrl #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .mux_out(mo2),
        .mux_sel(sel2), .snapshot(snap2), .scan_cnt(cnt2), .busy(busy2), .done(done2)
    );

    mux64_scan_ctrl #(.SETTLE(5)) u_dut5 (
        .clk(clk), .rst(rst), .start(start), .mask(mask), .mux_out(mo5),
        .mux_sel(sel5), .snapshot(snap5), .scan_cnt(cnt5), .busy(busy5), .done(done5)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- timeline model ----------------
    int          S[2] = '{2, 5};
    bit          m_active[2];
    int          m_t[2];
    int          m_k[2];
    int          m_ch[2][64];
    logic [63:0] m_data[2];
    logic [5:0]  m_sel[2];
    logic [63:0] m_snap[2];
    logic [6:0]  m_cnt[2];
    bit          m_busy[2];
    bit          m_done[2];

    task automatic model_reset(input int u);
        m_active[u] = 0; m_t[u] = 0; m_k[u] = 0;
        m_sel[u] = '0; m_snap[u] = '0; m_cnt[u] = '0;
        m_busy[u] = 0; m_done[u] = 0;
    endtask

    // Outputs t edges after the accepted start: j channels sampled so far,
    // the (j)th enabled channel selected, done exactly at t = k*S.
    task automatic derive(input int u);
        int k;
        int j;
        k = m_k[u];
        if (k == 0) begin
            m_done[u] = 1; m_busy[u] = 0; m_cnt[u] = '0; m_snap[u] = '0;
        end else begin
            j = m_t[u] / S[u];
            if (j > k) j = k;
            m_sel[u]  = 6'(m_ch[u][(j < k) ? j : k - 1]);
            m_cnt[u]  = 7'(j);
            m_snap[u] = '0;
            for (int i = 0; i < j; i++) m_snap[u][m_ch[u][i]] = m_data[u][m_ch[u][i]];
            m_busy[u] = (m_t[u] < k * S[u]);
            m_done[u] = (m_t[u] == k * S[u]);
        end
    endtask

    task automatic model_step(input int u);
        if (!m_active[u]) begin
            m_done[u] = 0;
            if (start) begin
                m_k[u] = 0;
                for (int i = 0; i < 64; i++) begin
                    if (mask[i]) begin
                        m_ch[u][m_k[u]] = i;
                        m_k[u]++;
                    end
                end
                m_data[u]   = in_data;
                m_t[u]      = 0;
                m_active[u] = 1;
                derive(u);
            end
        end else if (m_t[u] == m_k[u] * S[u]) begin
            m_active[u] = 0; m_done[u] = 0; m_busy[u] = 0;
        end else begin
            m_t[u]++;
            derive(u);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset(0); model_reset(1);
        end else begin
            model_step(0); model_step(1);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_unit(input int u, input logic [5:0] sel, input logic [63:0] snap,
                            input logic [6:0] cnt, input logic bz, input logic dn);
        chk($sformatf("s%0d.mux_sel", S[u]),  64'(sel),  64'(m_sel[u]));
        chk($sformatf("s%0d.snapshot", S[u]), snap,      m_snap[u]);
        chk($sformatf("s%0d.scan_cnt", S[u]), 64'(cnt),  64'(m_cnt[u]));
        chk($sformatf("s%0d.busy", S[u]),     64'(bz),   64'(m_busy[u]));
        chk($sformatf("s%0d.done", S[u]),     64'(dn),   64'(m_done[u]));
    endtask

    // Single compare process against the model, away from the active edge.
    always @(negedge clk) begin
        chk_unit(0, sel2, snap2, cnt2, busy2, done2);
        chk_unit(1, sel5, snap5, cnt5, busy5, done5);
    end

    // ---------------- directed helpers ----------------
    // Launches a scan; e counts edges from the accepting edge (edge 0).
    task automatic run_scan(input logic [63:0] m, input int disturb,
                            output int de2, output int de5,
                            output int nd2, output int nd5, output bit busy_seen);
        de2 = -1; de5 = -1; nd2 = 0; nd5 = 0; busy_seen = 0;
        @(negedge clk);
        mask  = m;
        start = 1'b1;
        for (int e = 0; e < 1000; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
            if (disturb >= 0 && e == disturb) begin
                start = 1'b1;
                mask  = '0;
            end
            if (disturb >= 0 && e == disturb + 1) start = 1'b0;
            if (busy2 || busy5) busy_seen = 1;
            if (done2) begin nd2++; if (de2 < 0) de2 = e; end
            if (done5) begin nd5++; if (de5 < 0) de5 = e; end
            if (de2 >= 0 && de5 >= 0 && e > de2 + 2 && e > de5 + 2) return;
        end
        checks++;
        errors++;
        $display("FAIL scan_timeout actual=no_done required=done_within_1000");
    endtask

    task automatic wait_model_idle();
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!m_active[0] && !m_active[1]) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout actual=busy required=idle");
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sel2"},  64'(sel2),  64'd0);
        chk({tag, ".snap2"}, snap2,      64'd0);
        chk({tag, ".cnt2"},  64'(cnt2),  64'd0);
        chk({tag, ".busy2"}, 64'(busy2), 64'd0);
        chk({tag, ".done2"}, 64'(done2), 64'd0);
        chk({tag, ".sel5"},  64'(sel5),  64'd0);
        chk({tag, ".snap5"}, snap5,      64'd0);
        chk({tag, ".cnt5"},  64'(cnt5),  64'd0);
    endtask

    int de2, de5, nd2, nd5;
    bit bsy;

    initial begin
        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            start = 1'($urandom);
            mask  = {$urandom, $urandom};
            @(negedge clk);
        end
        chk_zero("reset");
        #2;
        rst   = 1'b0;
        start = 1'b0;

        // Full scan
        run_scan(ALL_ONES, -1, de2, de5, nd2, nd5, bsy);
        chk("full.done_edge2", 64'(de2), 64'd128);
        chk("full.done_edge5", 64'(de5), 64'd320);
        chk("full.ndone2",     64'(nd2), 64'd1);
        chk("full.ndone5",     64'(nd5), 64'd1);
        chk("full.snap2",      snap2, IN_FIXED);
        chk("full.snap5",      snap5, IN_FIXED);
        chk("full.cnt2",       64'(cnt2), 64'd64);
        chk("full.cnt5",       64'(cnt5), 64'd64);

        // Sparse mask: channels 0 and 63
        run_scan(64'h8000_0000_0000_0001, -1, de2, de5, nd2, nd5, bsy);
        chk("sparse.done_edge2", 64'(de2), 64'd4);
        chk("sparse.done_edge5", 64'(de5), 64'd10);
        chk("sparse.snap2",      snap2, 64'h0000_0000_0000_0001);
        chk("sparse.snap5",      snap5, 64'h0000_0000_0000_0001);
        chk("sparse.cnt2",       64'(cnt2), 64'd2);
        chk("sparse.sel2",       64'(sel2), 64'd63);

        // Asynchronous reset asserted between edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Empty mask
        run_scan(64'd0, -1, de2, de5, nd2, nd5, bsy);
        chk("empty.done_edge2", 64'(de2), 64'd0);
        chk("empty.done_edge5", 64'(de5), 64'd0);
        chk("empty.busy_seen",  64'(bsy), 64'd0);
        chk("empty.snap2",      snap2, 64'd0);
        chk("empty.cnt2",       64'(cnt2), 64'd0);

        // start and mask changes during a scan are ignored
        run_scan(ALL_ONES, 10, de2, de5, nd2, nd5, bsy);
        chk("ignore.done_edge2", 64'(de2), 64'd128);
        chk("ignore.ndone2",     64'(nd2), 64'd1);
        chk("ignore.ndone5",     64'(nd5), 64'd1);
        chk("ignore.snap2",      snap2, IN_FIXED);
        chk("ignore.cnt2",       64'(cnt2), 64'd64);
        chk("ignore.cnt5",       64'(cnt5), 64'd64);

        // Reset mid-scan, then a scan over channels 4..7
        nd2 = 0;
        @(negedge clk);
        mask  = ALL_ONES;
        start = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
            if (done2 || done5) nd2++;
        end
        #2;
        rst = 1'b1;
        #1;
        chk_zero("midscan_rst");
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(negedge clk);
            if (done2 || done5) nd2++;
        end
        chk("midscan.no_done", 64'(nd2), 64'd0);
        run_scan(64'h0000_0000_0000_00F0, -1, de2, de5, nd2, nd5, bsy);
        chk("f0.snap2",      snap2, 64'h0000_0000_0000_00E0);
        chk("f0.snap5",      snap5, 64'h0000_0000_0000_00E0);
        chk("f0.cnt2",       64'(cnt2), 64'd4);
        chk("f0.done_edge2", 64'(de2), 64'd8);
        chk("f0.done_edge5", 64'(de5), 64'd20);

        // Randomized phase: random data per phase, random start/mask per cycle
        for (int it = 0; it < 6; it++) begin
            wait_model_idle();
            in_data = {$urandom, $urandom};
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                start = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 3))
                    0: mask = ALL_ONES;
                    1: mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
                    2: mask = '0;
                    default: mask = 64'd1 << $urandom_range(0, 63);
                endcase
            end
            @(negedge clk);
            start = 1'b0;
        end
        wait_model_idle();
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
